axi_sram_slave: RTL
===================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width; memory holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have port aclk  input  1  sole clock, rising edge.
REQ-003 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port arid  input  4  read ID.
REQ-005 SHALL have port araddr  input  32  read byte address.
REQ-006 SHALL have port arlen  input  8  read beats minus 1 (0..15).
REQ-007 SHALL have port arvalid  input  1  read address valid.
REQ-008 SHALL have port arready  output  1  read address accepted.
REQ-009 SHALL have port rid  output  4  read response ID.
REQ-010 SHALL have port rdata  output  32  read data.
REQ-011 SHALL have port rresp  output  2  read status, constant 2'b00.
REQ-012 SHALL have port rlast  output  1  final read beat.
REQ-013 SHALL have port rvalid  output  1  read data valid.
REQ-014 SHALL have port rready  input  1  master accepts read data.
REQ-015 SHALL have port awid  input  4  write ID.
REQ-016 SHALL have port awaddr  input  32  write byte address.
REQ-017 SHALL have port awlen  input  8  write beats minus 1 (0..15).
REQ-018 SHALL have port awvalid  input  1  write address valid.
REQ-019 SHALL have port awready  output  1  write address accepted.
REQ-020 SHALL have port wdata  input  32  write data.
REQ-021 SHALL have port wstrb  input  4  byte enables.
REQ-022 SHALL have port wvalid  input  1  write data valid.
REQ-023 SHALL have port wready  output  1  write data accepted.
REQ-024 SHALL have port bid  output  4  write response ID, latched awid.
REQ-025 SHALL have port bresp  output  2  write status, constant 2'b00.
REQ-026 SHALL have port bvalid  output  1  write response valid.
REQ-027 SHALL have port bready  input  1  master accepts response.

Function
REQ-028 Read FSM SHALL have states R_IDLE, R_DATA; arready = (R_IDLE & ~areset); AR handshake latches arid, araddr[ADDR_W+1:2], arlen, beat counter=0, enters R_DATA.
REQ-029 In R_DATA rvalid SHALL be asserted from the cycle after AR handshake (1-cycle latency), held with stable rid/rdata/rlast until rvalid&rready.
REQ-030 Each R handshake SHALL increment word address modulo 2^ADDR_W (INCR only; size 4 bytes, low 2 address bits ignored); next beat valid the following cycle; rlast = (counter==len); handshake on rlast returns to R_IDLE, arready high next cycle.
REQ-031 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready = (W_IDLE & ~areset); AW handshake latches awid, word address, awlen, enters W_DATA.
REQ-032 In W_DATA wready SHALL be 1; each W handshake writes bytes where wstrb[i]=1, increments address modulo 2^ADDR_W; beat with counter==len enters W_RESP (wlast not a port; length from awlen only).
REQ-033 In W_RESP bvalid SHALL be 1 with bid held until bready, then W_IDLE.
REQ-034 Read and write FSMs SHALL run concurrently; memory has independent read and write ports; same-cycle read and write of one word returns old data (read-first).
REQ-035 arlen/awlen above 15 SHALL be truncated to bits [3:0].

Reset
REQ-036 On areset both FSMs SHALL go idle asynchronously, rvalid, rlast, bvalid, arready, awready, wready=0, rid, bid, rdata=0; in-flight bursts abandoned; memory contents retained.

Configuration
REQ-037 With AXI_SLV_RAND_DELAY_EN defined, a 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1 on reset, steps every cycle) SHALL gate arready, awready, wready with lfsr[0] and defer assertion of each new rvalid beat while lfsr[1]==0 (asserted rvalid never dropped early).
REQ-038 Without AXI_SLV_RAND_DELAY_EN, no LFSR SHALL exist and handshake timing SHALL be exactly as REQ-028..REQ-033.

Verification
REQ-039 Write awid=3, awaddr=0x100, awlen=3, data 0x11..0x44, wstrb=F -> bvalid with bid=3, bresp=0 after 4th W beat.
REQ-040 Then read arid=5, araddr=0x100, arlen=3, rready=1 -> rvalid first cycle after AR, rdata 0x11,0x22,0x33,0x44, rlast on 4th, rid=5.
REQ-041 Write 0xAABBCCDD wstrb=4'b0101 over 0x11223344 at 0x200 -> read returns 0x11BB33DD.
REQ-042 Read araddr=0x3FFC (ADDR_W=12), arlen=1 -> beats from word 0xFFF then word 0x000.
REQ-043 areset mid read burst (beat 2 of 4) -> rvalid=0 immediately, arready=1 after release, prior memory data readable.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4-style slave in front of a 2^ADDR_W x 32-bit SRAM.
//   Supports INCR bursts of 1..16 beats with a fixed transfer size of 4 bytes.
//   The read and write channels run concurrently.
//   The memory has one read port and one write port. A read and a write of the
//   same word in the same cycle return the old data (read-first).
//
// Optional build macro:
//   AXI_SLV_RAND_DELAY_EN - adds a 16-bit LFSR that throttles the ready signals
//                           and delays each new read beat. It is used for
//                           backpressure stress testing.
//
// Ports:
//   aclk, areset                       clock and asynchronous active-high reset
//   arid/araddr/arlen/arvalid/arready  read address channel
//   rid/rdata/rresp/rlast/rvalid/rready read data channel
//   awid/awaddr/awlen/awvalid/awready  write address channel
//   wdata/wstrb/wvalid/wready          write data channel (no wlast; awlen sets the length)
//   bid/bresp/bvalid/bready            write response channel
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high. A source holds valid and its payload stable
// until that edge.
module axi_sram_slave #(
    parameter int ADDR_W = 12
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t          r_state;
    w_state_t          w_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_len;
    logic [3:0]        w_cnt;
    logic [31:0]       mem [0:(2**ADDR_W)-1];

    // hs_gate throttles the ready outputs.
    // beat_gate allows a new read beat to become valid.
    logic hs_gate;
    logic beat_gate;

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR with taps 16,14,13,11. It steps every cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign hs_gate   = lfsr[0];
    assign beat_gate = lfsr[1];
`else
    assign hs_gate   = 1'b1;
    assign beat_gate = 1'b1;
`endif

    assign arready = (r_state == R_IDLE) & ~areset & hs_gate;
    assign awready = (w_state == W_IDLE) & ~areset & hs_gate;
    assign wready  = (w_state == W_DATA) & hs_gate;
    assign bvalid  = (w_state == W_RESP);
    assign rresp   = 2'b00;
    assign bresp   = 2'b00;

    logic ar_fire;
    logic r_fire;
    logic aw_fire;
    logic w_fire;
    assign ar_fire = arvalid & arready;
    assign r_fire  = rvalid & rready;
    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;

    // Address bits outside the word index and the upper length bits are ignored.
    logic unused_bits;
    assign unused_bits = ^{araddr[31:ADDR_W+2], araddr[1:0], arlen[7:4],
                           awaddr[31:ADDR_W+2], awaddr[1:0], awlen[7:4]};

    // Read FSM.
    // rdata is loaded from the memory in the same cycle that rvalid is raised,
    // so each beat appears one cycle after the event that requested it.
    // rvalid drops only when a beat is accepted; with rready held high,
    // back-to-back beats stream with no gaps.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            rid     <= '0;
            rdata   <= '0;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_state <= R_DATA;
                        rid     <= arid;
                        r_addr  <= araddr[ADDR_W+1:2];
                        r_len   <= arlen[3:0];
                        r_cnt   <= '0;
                        rdata   <= mem[araddr[ADDR_W+1:2]];
                        rlast   <= (arlen[3:0] == 4'd0);
                        rvalid  <= beat_gate;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast) begin
                            r_state <= R_IDLE;
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_cnt   <= r_cnt + 4'd1;
                            rdata   <= mem[r_addr + ADDR_W'(1)];
                            rlast   <= ((r_cnt + 4'd1) == r_len);
                            rvalid  <= beat_gate;
                        end
                    end else if (!rvalid) begin
                        // The beat was deferred. Reload it and try again.
                        rdata  <= mem[r_addr];
                        rvalid <= beat_gate;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM. The burst length comes only from awlen; there is no wlast port.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            bid     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        w_state <= W_DATA;
                        bid     <= awid;
                        w_addr  <= awaddr[ADDR_W+1:2];
                        w_len   <= awlen[3:0];
                        w_cnt   <= '0;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= w_addr + ADDR_W'(1);
                        w_cnt  <= w_cnt + 4'd1;
                        if (w_cnt == w_len) w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory write port. It has no reset, so the contents survive areset.
    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[w_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
